// File: rtl/bru_bht_resolve_if.sv
// -----------------------------------------------------------------------------
// bru_bht_resolve_if
//
// Purpose: bundles the EX-stage branch request, the fetch-stage BHT lookup and
// the registered resolve result of bru_bht_resolve into one interface.
//
// Handshake: branch_valid is a qualifier with no ready. The unit accepts a
// branch on every clock edge where branch_valid=1 and flush=0. The result
// appears one cycle later with bru_valid=1 for exactly one cycle. bru_cancel
// and bru_wen are only ever high together with bru_valid. The data outputs
// (bru_taken, bru_target, bru_link_pc) are meaningful only while bru_valid=1,
// and hold their last value otherwise.
//
// Modports:
//   master : EX/fetch side. Drives the request and fetch_pc, and observes the
//            result.
//   slave  : the resolve unit. Consumes the request and produces
//            fetch_pred_taken plus all bru_* outputs.
//
// Parameters:
//   GRLEN        datapath / PC width (32 or 64); must match the unit's GRLEN.
//   BRU_CODE_BIT width of branch_op.
// -----------------------------------------------------------------------------
interface bru_bht_resolve_if #(
    parameter int GRLEN        = 32,
    parameter int BRU_CODE_BIT = 4
);
    // EX-stage request
    logic                    flush;
    logic                    branch_valid;
    logic [BRU_CODE_BIT-1:0] branch_op;
    logic [GRLEN-1:0]        branch_a;
    logic [GRLEN-1:0]        branch_b;
    logic [GRLEN-1:0]        branch_pc;
    logic [GRLEN-1:0]        branch_offset;
    logic                    pred_taken;
    logic [GRLEN-1:0]        pred_target;

    // Fetch-stage BHT lookup
    logic [GRLEN-1:0]        fetch_pc;
    logic                    fetch_pred_taken;

    // Registered resolve result
    logic                    bru_valid;
    logic                    bru_taken;
    logic [GRLEN-1:0]        bru_target;
    logic                    bru_cancel;
    logic [GRLEN-1:0]        bru_link_pc;
    logic                    bru_wen;

    modport master (
        output flush, branch_valid, branch_op, branch_a, branch_b,
               branch_pc, branch_offset, pred_taken, pred_target, fetch_pc,
        input  fetch_pred_taken, bru_valid, bru_taken, bru_target,
               bru_cancel, bru_link_pc, bru_wen
    );

    modport slave (
        input  flush, branch_valid, branch_op, branch_a, branch_b,
               branch_pc, branch_offset, pred_taken, pred_target, fetch_pc,
        output fetch_pred_taken, bru_valid, bru_taken, bru_target,
               bru_cancel, bru_link_pc, bru_wen
    );
endinterface

// File: rtl/bru_bht_resolve.sv
// -----------------------------------------------------------------------------
// bru_bht_resolve
//
// Purpose: registered branch resolution unit for the EX stage. It evaluates
// conditional branches, BL and JIRL, compares the outcome with the prediction
// carried from fetch, and raises a one-cycle cancel on a mispredict. It also
// owns a table of 2-bit saturating counters (the BHT): fetch reads it
// combinationally, and resolved conditional branches train it.
//
// Ports:
//   clk     clock
//   resetn  asynchronous active-low reset. It clears all bru_* outputs and
//           reloads every BHT counter with BHT_INIT.
//   bus     bru_bht_resolve_if.slave. It carries:
//             request : flush, branch_valid, branch_op, branch_a, branch_b,
//                       branch_pc, branch_offset, pred_taken, pred_target
//             lookup  : fetch_pc -> fetch_pred_taken (combinational)
//             result  : bru_valid, bru_taken, bru_target, bru_cancel,
//                       bru_link_pc, bru_wen (all registered, 1-cycle latency)
//
// Op encoding (branch_op):
//   1 EQZ, 2 NEZ, 3 EQ, 4 NE, 5 LT, 6 GE, 7 LTU, 8 GEU, 9 BL, 10 JR (JIRL).
//   Codes 1..8 are the conditional branches that train the BHT. Any other code
//   resolves as not taken, writes no link register and leaves the BHT alone.
//
// Parameters:
//   GRLEN        32 or 64; must match the interface instance.
//   BHT_ENTRIES  power of two in 4..256.
//   BHT_INIT     counter reset value (01 = weakly not-taken).
// -----------------------------------------------------------------------------
module bru_bht_resolve #(
    parameter int         GRLEN       = 32,
    parameter int         BHT_ENTRIES = 16,
    parameter logic [1:0] BHT_INIT    = 2'b01
) (
    input  logic             clk,
    input  logic             resetn,
    bru_bht_resolve_if.slave bus
);

    localparam int IDX = $clog2(BHT_ENTRIES);

    localparam logic [3:0] OP_EQZ = 4'd1;
    localparam logic [3:0] OP_NEZ = 4'd2;
    localparam logic [3:0] OP_EQ  = 4'd3;
    localparam logic [3:0] OP_NE  = 4'd4;
    localparam logic [3:0] OP_LT  = 4'd5;
    localparam logic [3:0] OP_GE  = 4'd6;
    localparam logic [3:0] OP_LTU = 4'd7;
    localparam logic [3:0] OP_GEU = 4'd8;
    localparam logic [3:0] OP_BL  = 4'd9;
    localparam logic [3:0] OP_JR  = 4'd10;

    // ------------------------------------------------------------------
    // Condition evaluation (combinational on the EX inputs)
    // ------------------------------------------------------------------
    logic a_is_zero;
    logic a_eq_b;
    logic signed_lt;
    logic unsigned_lt;

    assign a_is_zero   = (bus.branch_a == '0);
    assign a_eq_b      = (bus.branch_a == bus.branch_b);
    assign signed_lt   = ($signed(bus.branch_a) < $signed(bus.branch_b));
    assign unsigned_lt = (bus.branch_a < bus.branch_b);

    logic is_cond;     // op is one of EQZ..GEU
    logic is_link;     // op writes the link register (BL, JR)
    logic is_jr;       // target is register-relative
    logic cond_true;

    always_comb begin
        is_cond   = 1'b0;
        is_link   = 1'b0;
        is_jr     = 1'b0;
        cond_true = 1'b0;
        case (bus.branch_op)
            OP_EQZ: begin is_cond = 1'b1; cond_true = a_is_zero;    end
            OP_NEZ: begin is_cond = 1'b1; cond_true = !a_is_zero;   end
            OP_EQ:  begin is_cond = 1'b1; cond_true = a_eq_b;       end
            OP_NE:  begin is_cond = 1'b1; cond_true = !a_eq_b;      end
            OP_LT:  begin is_cond = 1'b1; cond_true = signed_lt;    end
            OP_GE:  begin is_cond = 1'b1; cond_true = !signed_lt;   end
            OP_LTU: begin is_cond = 1'b1; cond_true = unsigned_lt;  end
            OP_GEU: begin is_cond = 1'b1; cond_true = !unsigned_lt; end
            OP_BL:  begin is_link = 1'b1;                           end
            OP_JR:  begin is_link = 1'b1; is_jr = 1'b1;             end
            default: ;  // unknown op: not taken, no link, no training
        endcase
    end

    // BL and JR are unconditional, so "link" doubles as "always taken".
    logic act_taken;
    assign act_taken = is_cond ? cond_true : is_link;

    // ------------------------------------------------------------------
    // Target / link computation (modulo 2^GRLEN, no overflow detection)
    // ------------------------------------------------------------------
    logic [GRLEN-1:0] pc_plus4;
    logic [GRLEN-1:0] pc_rel_target;
    logic [GRLEN-1:0] jr_sum;
    logic [GRLEN-1:0] jr_target;
    logic [GRLEN-1:0] act_target;

    assign pc_plus4      = bus.branch_pc + GRLEN'(4);
    // PC-relative targets are based on the word-aligned PC.
    assign pc_rel_target = {bus.branch_pc[GRLEN-1:2], 2'b00} + bus.branch_offset;
    // JIRL clears the low two bits of the sum, not of the operand.
    assign jr_sum        = bus.branch_a + bus.branch_offset;
    assign jr_target     = jr_sum & {{(GRLEN-2){1'b1}}, 2'b00};

    always_comb begin
        act_target = pc_plus4;
        if (act_taken) begin
            act_target = is_jr ? jr_target : pc_rel_target;
        end
    end

    logic mispredict;
    assign mispredict = (act_taken != bus.pred_taken)
                     || (act_taken && (act_target != bus.pred_target));

    // A branch is accepted only on an unflushed valid cycle. The same condition
    // gates BHT training.
    logic accept;
    assign accept = bus.branch_valid && !bus.flush;

    // ------------------------------------------------------------------
    // Result registers
    // ------------------------------------------------------------------
    logic             valid_q;
    logic             taken_q;
    logic [GRLEN-1:0] target_q;
    logic             cancel_q;
    logic [GRLEN-1:0] link_q;
    logic             wen_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
            target_q <= '0;
            cancel_q <= 1'b0;
            link_q   <= '0;
            wen_q    <= 1'b0;
        end else if (bus.flush) begin
            // A flush kills the strobes and the direction. Target and link
            // keep their old values because they are only read under bru_valid.
            // A cancel already on the outputs this cycle has been seen by
            // fetch, so clearing it at this edge retracts nothing.
            valid_q  <= 1'b0;
            taken_q  <= 1'b0;
            cancel_q <= 1'b0;
            wen_q    <= 1'b0;
        end else begin
            valid_q  <= bus.branch_valid;
            cancel_q <= bus.branch_valid && mispredict;
            wen_q    <= bus.branch_valid && is_link;
            if (bus.branch_valid) begin
                taken_q  <= act_taken;
                target_q <= act_target;
                link_q   <= pc_plus4;
            end
        end
    end

    assign bus.bru_valid   = valid_q;
    assign bus.bru_taken   = taken_q;
    assign bus.bru_target  = target_q;
    assign bus.bru_cancel  = cancel_q;
    assign bus.bru_link_pc = link_q;
    assign bus.bru_wen     = wen_q;

    // ------------------------------------------------------------------
    // Branch history table
    // ------------------------------------------------------------------
    logic [1:0]     bht_q [BHT_ENTRIES];
    logic [IDX-1:0] wr_idx;
    logic [IDX-1:0] rd_idx;

    assign wr_idx = bus.branch_pc[IDX+1:2];
    assign rd_idx = bus.fetch_pc[IDX+1:2];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= BHT_INIT;
            end
        end else if (accept && is_cond) begin
            if (act_taken) begin
                if (bht_q[wr_idx] != 2'b11) begin
                    bht_q[wr_idx] <= bht_q[wr_idx] + 2'd1;
                end
            end else begin
                if (bht_q[wr_idx] != 2'b00) begin
                    bht_q[wr_idx] <= bht_q[wr_idx] - 2'd1;
                end
            end
        end
    end

    // The lookup reads the registered counter. An update at the coming edge
    // is therefore not visible until the following cycle.
    assign bus.fetch_pred_taken = bht_q[rd_idx][1];

    // Only the index slice of fetch_pc selects an entry.
    logic unused_fetch_bits;
    assign unused_fetch_bits = ^{bus.fetch_pc[GRLEN-1:IDX+2], bus.fetch_pc[1:0]};

endmodule

// File: tb/tb_bru_bht_resolve.sv
// -----------------------------------------------------------------------------
// tb_bru_bht_resolve
//
// Bench for bru_bht_resolve at GRLEN=64 with 16 BHT entries. Each accepted
// branch pushes its expected result into exp_q. A monitor pops one entry for
// every bru_valid cycle and compares it against the DUT outputs. The BHT is
// modelled as an array of integer counters held in the range 0..3.
// -----------------------------------------------------------------------------
module tb_bru_bht_resolve;

  localparam int GRLEN = 64;
  localparam int N_BHT = 16;

  localparam logic [3:0] OP_EQZ = 4'd1;
  localparam logic [3:0] OP_NEZ = 4'd2;
  localparam logic [3:0] OP_EQ  = 4'd3;
  localparam logic [3:0] OP_NE  = 4'd4;
  localparam logic [3:0] OP_LT  = 4'd5;
  localparam logic [3:0] OP_GE  = 4'd6;
  localparam logic [3:0] OP_LTU = 4'd7;
  localparam logic [3:0] OP_GEU = 4'd8;
  localparam logic [3:0] OP_BL  = 4'd9;
  localparam logic [3:0] OP_JR  = 4'd10;

  typedef struct packed {
    logic        taken;
    logic [63:0] target;
    logic        cancel;
    logic        wen;
    logic [63:0] link;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic resetn;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bru_bht_resolve_if #(.GRLEN(GRLEN), .BRU_CODE_BIT(4)) bus ();

  bru_bht_resolve #(
    .GRLEN(GRLEN),
    .BHT_ENTRIES(N_BHT),
    .BHT_INIT(2'b01)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  // ---------------- scoreboard state ----------------
  exp_t exp_q[$];
  int   cnt[N_BHT];
  int   n_vec = 0;
  int   n_err = 0;
  exp_t mon_e;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void ref_resolve(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] pc, input logic [63:0] off,
                                      output logic tk, output logic [63:0] tgt,
                                      output logic lnk, output logic upd);
    logic [63:0] sb;
    sb  = 64'h1 << 63;
    tk  = 1'b0;
    lnk = 1'b0;
    upd = 1'b0;
    case (op)
      OP_EQZ: begin upd = 1'b1; tk = (a == 0); end
      OP_NEZ: begin upd = 1'b1; tk = (a != 0); end
      OP_EQ:  begin upd = 1'b1; tk = (a == b); end
      OP_NE:  begin upd = 1'b1; tk = (a != b); end
      // Signed order = unsigned order with the sign bit inverted.
      OP_LT:  begin upd = 1'b1; tk = ((a ^ sb) <  (b ^ sb)); end
      OP_GE:  begin upd = 1'b1; tk = ((a ^ sb) >= (b ^ sb)); end
      OP_LTU: begin upd = 1'b1; tk = (a <  b); end
      OP_GEU: begin upd = 1'b1; tk = (a >= b); end
      OP_BL:  begin tk = 1'b1; lnk = 1'b1; end
      OP_JR:  begin tk = 1'b1; lnk = 1'b1; end
      default: ;
    endcase
    if (!tk)              tgt = pc + 64'd4;
    else if (op == OP_JR) tgt = ((a + off) >> 2) << 2;
    else                  tgt = ((pc >> 2) << 2) + off;
  endfunction

  function automatic int bht_idx(input logic [63:0] pc);
    return int'((pc >> 2) % 64'(N_BHT));
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic v, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] pc, input logic [63:0] off, input logic pt,
                       input logic [63:0] ptg, input logic [63:0] fpc, input logic fl);
    logic tk, lk, up;
    logic [63:0] tg;
    exp_t e;
    int wi;
    @(negedge clk);
    bus.branch_valid  = v;
    bus.branch_op     = op;
    bus.branch_a      = a;
    bus.branch_b      = b;
    bus.branch_pc     = pc;
    bus.branch_offset = off;
    bus.pred_taken    = pt;
    bus.pred_target   = ptg;
    bus.fetch_pc      = fpc;
    bus.flush         = fl;
    #1;
    // Lookup must show the counter as it stands before this cycle's update.
    chk("fetch_pred", bus.fetch_pred_taken, (cnt[bht_idx(fpc)] >= 2));
    ref_resolve(op, a, b, pc, off, tk, tg, lk, up);
    if (v && !fl) begin
      e.taken  = tk;
      e.target = tg;
      e.cancel = (tk != pt) || (tk && (tg != ptg));
      e.wen    = lk;
      e.link   = pc + 64'd4;
      exp_q.push_back(e);
      if (up) begin
        wi = bht_idx(pc);
        cnt[wi] = tk ? ((cnt[wi] < 3) ? cnt[wi] + 1 : 3) : ((cnt[wi] > 0) ? cnt[wi] - 1 : 0);
      end
    end
  endtask

  task automatic idle(input logic [63:0] fpc);
    issue(1'b0, 4'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0, fpc, 1'b0);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_valid"},  bus.bru_valid,   0);
    chk({tag, "_taken"},  bus.bru_taken,   0);
    chk({tag, "_target"}, bus.bru_target,  0);
    chk({tag, "_cancel"}, bus.bru_cancel,  0);
    chk({tag, "_link"},   bus.bru_link_pc, 0);
    chk({tag, "_wen"},    bus.bru_wen,     0);
  endtask

  // Pull reset mid-cycle, away from any edge, and verify without a clock.
  task automatic async_reset(input string tag);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    bus.branch_valid = 1'b0;
    bus.flush        = 1'b0;
    #1;
    check_outputs_zero(tag);
    exp_q.delete();
    for (int i = 0; i < N_BHT; i++) cnt[i] = 1;
    for (int i = 0; i < N_BHT; i++) begin
      bus.fetch_pc = 64'(i * 4);
      #0.5;
      chk({tag, "_bht"}, bus.fetch_pred_taken, 0);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    #1;
    if (resetn) begin
      if (bus.bru_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_valid: got bru_valid=1 expected no result (t=%0t)", $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("taken",  bus.bru_taken,   mon_e.taken);
          chk("target", bus.bru_target,  mon_e.target);
          chk("cancel", bus.bru_cancel,  mon_e.cancel);
          chk("wen",    bus.bru_wen,     mon_e.wen);
          chk("link",   bus.bru_link_pc, mon_e.link);
        end
      end else begin
        chk("idle_cancel", bus.bru_cancel, 0);
        chk("idle_wen",    bus.bru_wen,    0);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "bench timed out");
  end

  // ---------------- stimulus ----------------
  logic [63:0] ra, rb, rpc, roff, rptg, rfpc;
  logic [3:0]  rop;
  logic        rpt, rtk, rlk, rup;
  logic [63:0] rtg;

  initial begin
    resetn = 1'b0;
    bus.flush = 1'b0;
    bus.branch_valid = 1'b0;
    bus.branch_op = '0;
    bus.branch_a = '0;
    bus.branch_b = '0;
    bus.branch_pc = '0;
    bus.branch_offset = '0;
    bus.pred_taken = 1'b0;
    bus.pred_target = '0;
    bus.fetch_pc = '0;
    for (int i = 0; i < N_BHT; i++) cnt[i] = 1;

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    for (int i = 0; i < N_BHT; i++) begin
      bus.fetch_pc = 64'(i * 4);
      #0.5;
      chk("reset_bht", bus.fetch_pred_taken, 0);
    end
    @(negedge clk);
    resetn = 1'b1;

    // Directed resolves
    issue(1, OP_EQ,  64'd5, 64'd5, 64'h1000, 64'h20, 0, 64'h1004, 64'h0, 0);
    issue(1, OP_LT,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h3008, 64'h100, 1, 64'h3108, 64'h0, 0);
    issue(1, OP_LTU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h3008, 64'h100, 0, 64'h300C, 64'h0, 0);
    issue(1, OP_JR,  64'h2003, 64'd0, 64'h400, 64'd4, 1, 64'h2004, 64'h0, 0);
    issue(1, OP_JR,  64'h2003, 64'd0, 64'h400, 64'd4, 1, 64'h2008, 64'h0, 0);
    issue(1, OP_BL,  64'd0, 64'd0, 64'h500, 64'hFFFF_FFFF_FFFF_FFF8, 1, 64'h4F8, 64'h0, 0);
    issue(1, OP_GE,  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h600, 64'h40, 0, 64'h604, 64'h0, 0);
    issue(1, 4'd13,  64'd0, 64'd0, 64'h700, 64'h40, 1, 64'h740, 64'h0, 0);
    async_reset("rst_mid");

    // Training at pc=0x40 (entry 0): 3 taken then 4 not taken
    for (int i = 0; i < 3; i++) issue(1, OP_NE, 64'd1, 64'd2, 64'h40, 64'h10, 1, 64'h50, 64'h40, 0);
    for (int i = 0; i < 4; i++) issue(1, OP_NE, 64'd7, 64'd7, 64'h40, 64'h10, 0, 64'h44, 64'h40, 0);
    idle(64'h40);

    // Alias pc=0x40+4*N_BHT hits entry 0; read during write sees the old value
    issue(1, OP_EQ, 64'd3, 64'd3, 64'h80, 64'h8, 1, 64'h88, 64'h40, 0);
    issue(1, OP_EQ, 64'd3, 64'd3, 64'h80, 64'h8, 1, 64'h88, 64'h40, 0);
    idle(64'h40);

    // Flush a mispredicting branch: no pulses, no training
    issue(1, OP_NE, 64'd1, 64'd2, 64'h40, 64'h10, 0, 64'h44, 64'h40, 1);
    @(posedge clk);
    #1;
    chk("flush_valid",  bus.bru_valid,  0);
    chk("flush_cancel", bus.bru_cancel, 0);
    chk("flush_wen",    bus.bru_wen,    0);
    chk("flush_taken",  bus.bru_taken,  0);
    idle(64'h40);
    issue(1, OP_NE, 64'd7, 64'd7, 64'h40, 64'h10, 0, 64'h44, 64'h40, 0);
    idle(64'h40);

    // Flush in the cycle a cancel is on the outputs leaves it visible
    issue(1, OP_EQ, 64'd1, 64'd1, 64'h200, 64'h20, 0, 64'h204, 64'h0, 0);
    issue(0, 4'd0, 64'd0, 64'd0, 64'd0, 64'd0, 0, 64'd0, 64'h0, 1);
    chk("cancel_hold", bus.bru_cancel, 1);
    idle(64'h0);

    // Reset again with counters disturbed; then prove every entry is 01
    // by one taken update each (01 -> 10 flips the prediction).
    issue(1, OP_EQ, 64'd2, 64'd2, 64'h40, 64'h8, 1, 64'h48, 64'h40, 0);
    async_reset("rst_again");
    for (int i = 0; i < N_BHT; i++)
      issue(1, OP_EQZ, 64'd0, 64'd0, 64'(i * 4), 64'h40, 1, 64'(i * 4 + 64), 64'(i * 4), 0);
    for (int i = 0; i < N_BHT; i++) idle(64'(i * 4));

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      rop  = 4'($urandom_range(0, 12));
      rpc  = {$urandom, $urandom};
      roff = {{32{1'b0}}, $urandom} - 64'h8000_0000;
      case ($urandom_range(0, 3))
        0: begin ra = {$urandom, $urandom}; rb = ra; end
        1: begin ra = 64'd0; rb = {$urandom, $urandom}; end
        2: begin ra = {$urandom, $urandom}; rb = {$urandom, $urandom}; end
        default: begin
          ra = 64'($urandom_range(0, 3)) - 64'd1;
          rb = 64'($urandom_range(0, 3)) - 64'd1;
        end
      endcase
      ref_resolve(rop, ra, rb, rpc, roff, rtk, rtg, rlk, rup);
      if ($urandom_range(0, 1) == 1) begin
        rpt  = rtk;
        rptg = rtg;
      end else begin
        rpt  = 1'($urandom_range(0, 1));
        rptg = ($urandom_range(0, 1) == 1) ? rtg + 64'd4 : {$urandom, $urandom};
      end
      rfpc = ($urandom_range(0, 1) == 1) ? rpc : {$urandom, $urandom};
      issue(($urandom_range(0, 9) < 8), rop, ra, rb, rpc, roff, rpt, rptg, rfpc,
            ($urandom_range(0, 9) == 0));
    end

    idle(64'h0);
    idle(64'h0);
    chk("queue_empty", 64'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bru_bht_resolve.md
Name: bru_bht_resolve

Overview:
- Parametrised, registered branch resolution unit for the EX stage.
- Evaluates conditional branches, `BL` and `JIRL` at any `GRLEN`, and checks the outcome against the fetch-stage prediction.
- Raises a one-cycle cancel/redirect on mispredict.
- Owns a 2-bit saturating-counter branch history table (BHT) that fetch reads combinationally and resolution trains.

Parameters:
- GRLEN, 32, datapath/PC width; must be 32 or 64.
- BHT_ENTRIES, 16, number of 2-bit counters; power of 2, range 4..256.
- BHT_INIT, 2'b01, counter reset value (weakly not-taken).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- flush  in  1  pipeline flush; kills the resolve in flight.
- branch_valid  in  1  EX-stage branch valid.
- branch_op  in  `LSOC1K_BRU_CODE_BIT`  op code; `LSOC1K_BRU_*` from decoded.vh.
- branch_a  in  GRLEN  rj operand.
- branch_b  in  GRLEN  rd operand.
- branch_pc  in  GRLEN  branch instruction PC.
- branch_offset  in  GRLEN  sign-extended byte offset.
- pred_taken  in  1  prediction carried down from fetch.
- pred_target  in  GRLEN  predicted next PC from fetch.
- fetch_pc  in  GRLEN  BHT lookup PC.
- fetch_pred_taken  out  1  counter[1] of the looked-up entry; combinational.
- bru_valid  out  1  registered resolve valid.
- bru_taken  out  1  registered actual direction.
- bru_target  out  GRLEN  registered actual next PC.
- bru_cancel  out  1  registered mispredict; redirect fetch to bru_target.
- bru_link_pc  out  GRLEN  registered pc+4.
- bru_wen  out  1  registered link write enable (`BL`/`JIRL`).

Behaviour:
- Reset (resetn=0, async): all bru_* outputs 0; every BHT counter = BHT_INIT.
- Conditions, computed combinationally on the EX inputs:
  - EQZ: a==0. NEZ: a!=0. EQ: a==b. NE: a!=b.
  - LT/GE: signed, sign bit is GRLEN-1. LTU/GEU: unsigned.
  - BL and JR are always taken.
- Targets:
  - Taken non-JR: {pc[GRLEN-1:2],2'b00}+offset.
  - JR: a+offset, bits [1:0] forced to 00.
  - Not taken: pc+4.
  - link = pc+4.
  - All arithmetic is modulo 2^GRLEN; no overflow flag.
- Mispredict = (taken != pred_taken) || (taken && target != pred_target).
- Latency: 1 cycle. Inputs sampled at edge N appear on bru_* during cycle N+1. No backpressure; a new branch is accepted every cycle.
- bru_valid/bru_cancel/bru_wen are pulses of exactly one cycle per accepted branch. Data outputs hold their last value when bru_valid=0.
- flush=1 at an edge: bru_valid, bru_cancel, bru_wen and bru_taken are cleared, and that cycle's BHT update is suppressed.
- A flush arriving in the same cycle as a registered cancel does not retract the cancel already on the outputs.
- BHT index = pc[IDX+1:2], IDX=log2(BHT_ENTRIES). The same slice is applied to fetch_pc.
- BHT update at the edge when branch_valid && !flush && op is conditional (EQZ..GEU); BL/JR never update.
  - Taken: counter += 1, saturating at 11.
  - Not taken: counter -= 1, saturating at 00.
- Same-cycle read/write of one entry: fetch_pred_taken returns the pre-update value (no bypass).
- Unknown op code: treated as not taken, no BHT update, bru_wen=0, bru_valid follows branch_valid.
- Reset asserted mid-operation clears the outputs immediately (no clock needed). The BHT is reinitialised.

Test Plan:
- Reset, then drive EQ with a=b=5, pc=0x1000, offset=0x20, pred_taken=0, pred_target=0x1004. Required one cycle later: bru_valid=1, bru_taken=1, bru_target=0x1020, bru_cancel=1.
- GRLEN=64: BLT with a=0xFFFF_FFFF_FFFF_FFFF, b=1, correct prediction. Required: taken, cancel=0. BLTU with the same operands: not taken, bru_target=pc+4.
- JIRL with a=0x2003, offset=4, pc=0x400, pred_taken=1, pred_target=0x2004. Required: bru_target=0x2004, bru_wen=1, bru_link_pc=0x404, cancel=0. Repeat with pred_target=0x2008: cancel=1.
- BHT training: issue 3 taken BNE at pc=0x40 on consecutive cycles. Required: fetch_pred_taken(0x40) reads 0 (cycle 1), 1 (cycle 2), 1 thereafter; counter saturates at 11. Then 4 not-taken: counter reaches 00 and fetch_pred_taken=0.
- Simultaneous fetch_pc=0x40 lookup and update of index 0 from 01→10. Required: fetch_pred_taken=0 that cycle, 1 the next cycle. pc=0x40+4*BHT_ENTRIES aliases to the same entry.
- flush asserted with a mispredicting branch_valid. Required: no bru_valid/bru_cancel pulse and BHT unchanged. resetn pulsed low asynchronously mid-stream: outputs 0 immediately and all counters back to 01.
